logic_gate_unit_pipe: RTL and testbench

LOGIC_GATE_UNIT_PIPE -- requirements
Module: logic_gate_unit_pipe

---
 rtl/logic_gate_pkg.sv | 20 ++
 rtl/logic_gate_core.sv | 37 +++
 rtl/logic_gate_unit_pipe.sv | 85 ++++++++
 tb/tb_logic_gate_unit_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit.
// Holds the 3-bit opcode encodings used by the core and by anything that
// drives the op port.
package logic_gate_pkg;

    localparam int unsigned OP_W = 3;

    // Bitwise operation encodings
    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_NAND  = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_NOT_A = 3'd4,
        OP_XOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_PASS_A = 3'd7
    } gate_op_e;

endpackage : logic_gate_pkg

// File: rtl/logic_gate_core.sv
// Combinational bitwise operation decoder.
// Ports:
//   a, b    : WIDTH-bit operands
//   op      : 3-bit opcode (see logic_gate_pkg)
//   result  : WIDTH-bit bitwise result of op applied to a and b
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result
);

    gate_op_e op_e;

    assign op_e = gate_op_e'(op);

    // Opcode decode; every 3-bit code is a defined operation
    always_comb begin
        result = a;
        case (op_e)
            OP_AND:    result = a & b;
            OP_NAND:   result = ~(a & b);
            OP_OR:     result = a | b;
            OP_NOR:    result = ~(a | b);
            OP_NOT_A:  result = ~a;
            OP_XOR:    result = a ^ b;
            OP_XNOR:   result = ~(a ^ b);
            OP_PASS_A: result = a;
            default:   result = a;
        endcase
    end

endmodule : logic_gate_core

// File: rtl/logic_gate_unit_pipe.sv
// One-stage pipelined bitwise logic unit with an optional accumulator
// operand and registered result flags.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, op, acc_mode)
//   acc_clr             : synchronous accumulator clear request
//   out_valid/out_ready : result handshake
//   y                   : registered result
//   y_zero/y_ones/y_par : registered flags of y (==0, all ones, XOR-reduce)
//   acc                 : current accumulator value
module logic_gate_unit_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_ones,
    output logic             y_par,
    output logic [WIDTH-1:0] acc
);

    logic             accept;
    logic [WIDTH-1:0] eff_b;
    logic [WIDTH-1:0] result;

    // Single output register: free when empty or being drained this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A same-cycle clear makes the accumulate operand the reset value
    assign eff_b = acc_mode ? (acc_clr ? ACC_INIT : acc) : b;

    logic_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (a),
        .b      (eff_b),
        .op     (op),
        .result (result)
    );

    // Result register, flags and valid; held while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_zero    <= 1'b1;
            y_ones    <= 1'b0;
            y_par     <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= result;
            y_zero    <= (result == '0);
            y_ones    <= (&result);
            y_par     <= (^result);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator: an accumulate accept wins over a clear request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= ACC_INIT;
        end else if (accept && acc_mode) begin
            acc <= result;
        end else if (acc_clr) begin
            acc <= ACC_INIT;
        end
    end

endmodule : logic_gate_unit_pipe

// File: tb/tb_logic_gate_unit_pipe.sv
// Self-checking bench for logic_gate_unit_pipe (WIDTH=8, ACC_INIT=0).
// Directed scenarios plus randomized traffic against a truth-table model.
module tb_logic_gate_unit_pipe;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         acc_mode;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         y_zero;
    logic         y_ones;
    logic         y_par;
    logic [W-1:0] acc;

    always #5 clk = ~clk;

    logic_gate_unit_pipe #(
        .WIDTH    (W),
        .ACC_INIT (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_mode  (acc_mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_zero    (y_zero),
        .y_ones    (y_ones),
        .y_par     (y_par),
        .acc       (acc)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: one result slot and the accumulator
    logic         m_valid;
    logic [W-1:0] m_y;
    logic [W-1:0] m_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-bit truth table, indexed by {a_bit, b_bit}
    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] z);
        logic [3:0]   tt;
        logic [W-1:0] r;
        case (o)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b0111;
            3'd2:    tt = 4'b1110;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0011;
            3'd5:    tt = 4'b0110;
            3'd6:    tt = 4'b1001;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < int'(W); i++) r[i] = tt[{x[i], z[i]}];
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_y     = '0;
        m_acc   = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, "_y"},         64'(y),         64'(m_y));
        check({tag, "_y_zero"},    64'(y_zero),    64'(m_y == '0));
        check({tag, "_y_ones"},    64'(y_ones),    64'(m_y == '1));
        check({tag, "_y_par"},     64'(y_par),     64'(^m_y));
        check({tag, "_acc"},       64'(acc),       64'(m_acc));
    endtask

    // One clock: check in_ready, predict, clock, compare
    task automatic step(input string tag);
        logic         m_ready;
        logic         acc_ok;
        logic [W-1:0] opnd;
        logic [W-1:0] res;
        #1;
        m_ready = !m_valid || out_ready;
        check({tag, "_in_ready"}, 64'(in_ready), 64'(m_ready));
        acc_ok = in_valid && m_ready;
        opnd   = acc_mode ? (acc_clr ? 8'h00 : m_acc) : b;
        res    = ref_op(op, a, opnd);
        if (acc_ok) begin
            m_y     = res;
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (acc_ok && acc_mode) m_acc = res;
        else if (acc_clr)       m_acc = 8'h00;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    logic [W-1:0] sweep_exp [8];

    initial begin
        sweep_exp = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'h0F, 8'hCC, 8'h33, 8'hF0};
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
        acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check_outputs("rst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Opcode sweep; first accept on the first edge after reset
        in_valid = 1'b1; out_ready = 1'b1; a = 8'hF0; b = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            step("sweep");
            check("sweep_const", 64'(y), 64'(sweep_exp[i]));
        end

        // Backpressure: drain, accept, stall three cycles, resume
        in_valid = 1'b0;
        step("drain");
        in_valid = 1'b1; op = 3'd5; a = 8'h11; b = 8'h22; out_ready = 1'b0;
        step("bp_first");
        check("bp_first_const", 64'(y), 64'h33);
        a = 8'h44; b = 8'h88;
        for (int i = 0; i < 3; i++) begin
            step("bp_stall");
            check("bp_hold_y", 64'(y), 64'h33);
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        step("bp_resume");
        check("bp_second_const", 64'(y), 64'hCC);
        in_valid = 1'b0;
        step("bp_empty");
        check("bp_empty_valid", 64'(out_valid), 64'(0));

        // Accumulate with OR
        acc_clr = 1'b1;
        step("acc_clear");
        acc_clr = 1'b0; in_valid = 1'b1; acc_mode = 1'b1; op = 3'd2;
        a = 8'h01; step("acc1"); check("acc1_const", 64'(y), 64'h01);
        a = 8'h02; step("acc2"); check("acc2_const", 64'(y), 64'h03);
        a = 8'h04; step("acc3"); check("acc3_const", 64'(y), 64'h07);
        check("acc3_acc_const", 64'(acc), 64'h07);

        // Clear together with an accumulate accept
        acc_clr = 1'b1; op = 3'd5; a = 8'h55;
        step("accclr");
        check("accclr_y_const", 64'(y), 64'h55);
        check("accclr_acc_const", 64'(acc), 64'h55);
        acc_clr = 1'b0; acc_mode = 1'b0;

        // Flag corners
        op = 3'd5; a = 8'hA5; b = 8'hA5;
        step("flag_xor");
        check("flag_zero_const", 64'(y_zero), 64'(1));
        op = 3'd1; a = 8'h00; b = 8'h00;
        step("flag_nand");
        check("flag_ones_const", 64'(y_ones), 64'(1));
        check("flag_par_const", 64'(y_par), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom);
            acc_mode  = ($urandom_range(0, 2) == 0);
            acc_clr   = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        // Asynchronous reset while a result is stalled
        in_valid = 1'b1; out_ready = 1'b0; acc_mode = 1'b1; acc_clr = 1'b0;
        op = 3'd7; a = 8'h5A;
        if (!m_valid || out_ready) begin
            step("pre_rst");
        end else begin
            out_ready = 1'b1;
            step("pre_rst_drain");
            out_ready = 1'b0;
            step("pre_rst");
        end
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_rst");
        check("async_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // Accept immediately after reset release
        in_valid = 1'b1; out_ready = 1'b1; acc_mode = 1'b0; op = 3'd0;
        a = 8'hFF; b = 8'h81;
        step("post_rst");
        check("post_rst_const", 64'(y), 64'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_logic_gate_unit_pipe
